// File: rtl/video_fx_pipe_pkg.sv
// Shared types for the video post-processing path: scanline modes, sync/control bundles and
// the MSB-first colour replication helper.
package video_fx_pipe_pkg;

  typedef enum logic [1:0] {
    SL_OFF = 2'b00,
    SL_25  = 2'b01,
    SL_50  = 2'b10,
    SL_75  = 2'b11
  } sl_mode_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } sync_t;

  typedef struct packed {
    logic     blend;
    sl_mode_t sl;
    logic     csync;
  } ctrl_t;

  // c carries in_w bits right-aligned; the result is MSB-aligned so callers take the top bits.
  function automatic logic [7:0] expand_color(input logic [7:0] c, input int in_w);
    logic [7:0] e;
    int src;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      src = in_w - 1 - (i % in_w);
      e[7-i] = c[src[2:0]];
    end
    return e;
  endfunction

endpackage

// File: rtl/video_ce_gen.sv
// Pixel-enable source: CE_DIV divider resynced on HS falling edge, or external enable.
// Latency: registered internal enable, combinational ext mux; no backpressure.
module video_ce_gen #(
  parameter int CE_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic hs_in,
  input  logic ce_ext_en,
  input  logic ce_ext,
  output logic ce_pix
);

  localparam logic [3:0] LAST = 4'(CE_DIV - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       hs_d1_q, hs_d1_d;
  logic       ce_int_q, ce_int_d;

  always_comb begin
    hs_d1_d = hs_in;
    if (hs_d1_q && !hs_in) begin
      cnt_d = 4'd0;
    end else if (cnt_q == LAST) begin
      cnt_d = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    // Registering the compare keeps ce_int_q equal to (cnt_q == LAST) while resetting to 0.
    ce_int_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      hs_d1_q  <= 1'b1;
      ce_int_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hs_d1_q  <= hs_d1_d;
      ce_int_q <= ce_int_d;
    end
  end

  assign ce_pix = ce_ext_en ? ce_ext : ce_int_q;

endmodule

// File: rtl/video_fx_pipe.sv
// Per-pixel colour expansion, blend, scanlines, blanking and csync; colour and syncs 2 ce late.
// No backpressure: everything advances only on ce_pix and holds otherwise.
module video_fx_pipe #(
  parameter int IN_DEPTH  = 6,
  parameter int OUT_DEPTH = 6,
  parameter int CE_DIV    = 4,
  parameter int SL_PHASE  = 1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ce_ext_en,
  input  logic                 ce_ext,
  input  logic [IN_DEPTH-1:0]  r_in,
  input  logic [IN_DEPTH-1:0]  g_in,
  input  logic [IN_DEPTH-1:0]  b_in,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic                 hblank,
  input  logic                 vblank,
  input  logic                 blend,
  input  logic [1:0]           scanlines,
  input  logic                 csync_en,
  output logic                 ce_pix,
  output logic [OUT_DEPTH-1:0] r_out,
  output logic [OUT_DEPTH-1:0] g_out,
  output logic [OUT_DEPTH-1:0] b_out,
  output logic                 hs_out,
  output logic                 vs_out
);
  import video_fx_pipe_pkg::*;

  typedef struct packed {
    logic [OUT_DEPTH-1:0] r;
    logic [OUT_DEPTH-1:0] g;
    logic [OUT_DEPTH-1:0] b;
  } rgb_t;

  localparam logic  SL_BIT   = 1'(SL_PHASE);
  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, hb: 1'b1, vb: 1'b0};

  rgb_t  s1_pix_q, s1_pix_d, prev_q, prev_d, out_q, out_d;
  sync_t s1_sync_q, s1_sync_d;
  ctrl_t s1_ctrl_q, s1_ctrl_d;
  logic  first_q, first_d, line_q, line_d, hs_q, hs_d, vs_q, vs_d;
  logic  mix;
  sl_mode_t sl_eff;

  video_ce_gen #(.CE_DIV(CE_DIV)) u_ce_gen (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .hs_in     (hs_in),
    .ce_ext_en (ce_ext_en),
    .ce_ext    (ce_ext),
    .ce_pix    (ce_pix)
  );

  function automatic logic [OUT_DEPTH-1:0] widen(input logic [IN_DEPTH-1:0] c);
    logic [7:0] w;
    logic [7:0] e;
    w = '0;
    w[IN_DEPTH-1:0] = c;
    e = expand_color(w, IN_DEPTH);
    return e[7 -: OUT_DEPTH];
  endfunction

  function automatic logic [OUT_DEPTH-1:0] shade(input logic [OUT_DEPTH-1:0] cur,
                                                 input logic [OUT_DEPTH-1:0] prev,
                                                 input logic m, input sl_mode_t sl);
    logic [OUT_DEPTH:0]   sum;
    logic [OUT_DEPTH-1:0] c;
    sum = {1'b0, cur} + {1'b0, prev};
    c = m ? sum[OUT_DEPTH:1] : cur;
    case (sl)
      SL_25:   c = c - (c >> 2);
      SL_50:   c = c >> 1;
      SL_75:   c = c >> 2;
      default: c = c;
    endcase
    return c;
  endfunction

  always_comb begin
    s1_pix_d  = s1_pix_q;
    s1_sync_d = s1_sync_q;
    s1_ctrl_d = s1_ctrl_q;
    prev_d    = prev_q;
    out_d     = out_q;
    first_d   = first_q;
    line_d    = line_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    mix       = s1_ctrl_q.blend && !first_q;
    sl_eff    = (line_q == SL_BIT) ? s1_ctrl_q.sl : SL_OFF;
    if (ce_pix) begin
      s1_pix_d  = '{r: widen(r_in), g: widen(g_in), b: widen(b_in)};
      s1_sync_d = '{hs: hs_in, vs: vs_in, hb: hblank, vb: vblank};
      s1_ctrl_d = '{blend: blend, sl: sl_mode_t'(scanlines), csync: csync_en};
      // Frame start overrides the line toggle so the first line of a frame is always parity 0.
      if (s1_sync_q.vs && !vs_in) begin
        line_d = 1'b0;
      end else if (s1_sync_q.hs && !hs_in) begin
        line_d = !line_q;
      end
      prev_d  = s1_pix_q;
      first_d = s1_sync_q.hb;
      if (s1_sync_q.hb || s1_sync_q.vb) begin
        out_d = '0;
      end else begin
        out_d.r = shade(s1_pix_q.r, prev_q.r, mix, sl_eff);
        out_d.g = shade(s1_pix_q.g, prev_q.g, mix, sl_eff);
        out_d.b = shade(s1_pix_q.b, prev_q.b, mix, sl_eff);
      end
      hs_d = s1_ctrl_q.csync ? !(s1_sync_q.hs ^ s1_sync_q.vs) : s1_sync_q.hs;
      vs_d = s1_ctrl_q.csync | s1_sync_q.vs;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_pix_q  <= '0;
      s1_sync_q <= SYNC_RST;
      s1_ctrl_q <= '0;
      prev_q    <= '0;
      out_q     <= '0;
      first_q   <= 1'b1;
      line_q    <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      s1_pix_q  <= s1_pix_d;
      s1_sync_q <= s1_sync_d;
      s1_ctrl_q <= s1_ctrl_d;
      prev_q    <= prev_d;
      out_q     <= out_d;
      first_q   <= first_d;
      line_q    <= line_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign r_out  = out_q.r;
  assign g_out  = out_q.g;
  assign b_out  = out_q.b;
  assign hs_out = hs_q;
  assign vs_out = vs_q;

endmodule

// File: tb/tb_video_fx_pipe.sv
// Directed bench: 6-bit instance for CE, blend, scanlines, csync and reset; 3->6-bit instance for expansion.
module tb_video_fx_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_ext_en = 1'b0;
  logic       ce_ext = 1'b0;
  logic [5:0] pix_c = '0;
  logic [2:0] r3 = '0;
  logic       hs_in = 1'b1, vs_in = 1'b1, hblank = 1'b1, vblank = 1'b0;
  logic       blend = 1'b0, csync_en = 1'b0;
  logic [1:0] scanlines = 2'b00;

  logic       ce_pix, hs_out, vs_out;
  logic [5:0] r_out, g_out, b_out;
  logic       ce_pix3, hs_out3, vs_out3;
  logic [5:0] r_out3, g_out3, b_out3;

  int n_chk = 0;
  int n_fail = 0;
  logic [11:0] mask;

  always #5 clk = ~clk;

  video_fx_pipe #(.IN_DEPTH(6), .OUT_DEPTH(6), .CE_DIV(4), .SL_PHASE(1)) dut (
    .clk_sys(clk), .reset(reset), .ce_ext_en(ce_ext_en), .ce_ext(ce_ext),
    .r_in(pix_c), .g_in(pix_c), .b_in(pix_c), .hs_in(hs_in), .vs_in(vs_in),
    .hblank(hblank), .vblank(vblank), .blend(blend), .scanlines(scanlines),
    .csync_en(csync_en), .ce_pix(ce_pix), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hs_out(hs_out), .vs_out(vs_out)
  );

  video_fx_pipe #(.IN_DEPTH(3), .OUT_DEPTH(6), .CE_DIV(4), .SL_PHASE(1)) dut3 (
    .clk_sys(clk), .reset(reset), .ce_ext_en(ce_ext_en), .ce_ext(ce_ext),
    .r_in(r3), .g_in(r3), .b_in(r3), .hs_in(hs_in), .vs_in(vs_in),
    .hblank(hblank), .vblank(vblank), .blend(blend), .scanlines(scanlines),
    .csync_en(csync_en), .ce_pix(ce_pix3), .r_out(r_out3), .g_out(g_out3), .b_out(b_out3),
    .hs_out(hs_out3), .vs_out(vs_out3)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One externally-enabled pixel; returns at the negedge after the capturing edge.
  task automatic pix(input logic [5:0] c, input logic h, input logic v,
                     input logic hb, input logic vb);
    @(negedge clk);
    pix_c = c; hs_in = h; vs_in = v; hblank = hb; vblank = vb; ce_ext = 1'b1;
    @(negedge clk);
    ce_ext = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ce", 12'(ce_pix), 12'd0);
    chk("rst_r", 12'(r_out), 12'd0);
    chk("rst_hs", 12'(hs_out), 12'd1);
    chk("rst_vs", 12'(vs_out), 12'd1);
    reset = 1'b0;

    // Internal divider resync on HS fall
    repeat (10) @(negedge clk);
    hs_in = 1'b0;
    mask = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      mask[i] = ce_pix;
    end
    chk("ce_div_resync", mask, 12'h888);
    hs_in = 1'b1;
    repeat (8) @(negedge clk);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ce_ext_en = 1'b1;

    // Expansion and plain pass-through
    r3 = 3'b101;
    pix(6'd10, 1, 1, 0, 0);
    chk("latency_r", 12'(r_out), 12'd0);
    chk("latency_r3", 12'(r_out3), 12'd0);
    pix(6'd10, 1, 1, 0, 0);
    chk("expand_r3", 12'(r_out3), 12'd45);
    chk("expand_g3", 12'(g_out3), 12'd45);
    chk("passthru", 12'(r_out), 12'd10);
    pix(6'd0, 1, 1, 1, 0);

    // Horizontal blend
    blend = 1'b1;
    pix(6'd40, 1, 1, 0, 0);
    chk("blank_before", 12'(r_out), 12'd0);
    pix(6'd20, 1, 1, 0, 0);
    chk("blend_first", 12'(r_out), 12'd40);
    pix(6'd0, 1, 1, 1, 0);
    chk("blend_avg", 12'(b_out), 12'd30);
    pix(6'd0, 1, 1, 1, 0);
    chk("blend_hblank", 12'(r_out), 12'd0);

    // Scanlines 75% on odd lines
    blend = 1'b0; scanlines = 2'b11;
    pix(6'd63, 1, 1, 0, 0);
    pix(6'd0, 0, 1, 1, 0);
    chk("sl_line0", 12'(r_out), 12'd63);
    pix(6'd63, 1, 1, 0, 0);
    pix(6'd63, 1, 1, 0, 0);
    chk("sl_line1", 12'(r_out), 12'd15);
    pix(6'd0, 0, 1, 1, 0);
    pix(6'd63, 1, 1, 0, 0);
    pix(6'd63, 1, 1, 0, 0);
    chk("sl_line2", 12'(r_out), 12'd63);
    pix(6'd0, 0, 1, 1, 0);
    scanlines = 2'b01;
    pix(6'd63, 1, 1, 0, 0);
    scanlines = 2'b10;
    pix(6'd63, 1, 1, 0, 0);
    chk("sl_25", 12'(r_out), 12'd48);
    scanlines = 2'b00;
    pix(6'd63, 1, 1, 0, 0);
    chk("sl_50", 12'(r_out), 12'd31);
    pix(6'd63, 1, 1, 0, 0);
    chk("sl_off", 12'(r_out), 12'd63);

    // Parity back to 0, then HS and VS fall together: clear wins
    pix(6'd0, 0, 1, 1, 0);
    pix(6'd0, 1, 1, 1, 0);
    pix(6'd0, 0, 0, 1, 1);
    scanlines = 2'b11;
    pix(6'd63, 1, 1, 0, 0);
    pix(6'd63, 1, 1, 0, 0);
    chk("vs_clear_wins", 12'(r_out), 12'd63);
    scanlines = 2'b00;

    // Composite sync
    csync_en = 1'b1;
    pix(6'd0, 0, 1, 1, 0);
    chk("csync_delay", 12'(hs_out), 12'd1);
    pix(6'd0, 0, 0, 1, 0);
    chk("csync_hs_only", 12'(hs_out), 12'd0);
    chk("csync_vs_held", 12'(vs_out), 12'd1);
    pix(6'd0, 1, 1, 1, 0);
    chk("csync_both", 12'(hs_out), 12'd1);
    csync_en = 1'b0;
    pix(6'd0, 1, 0, 1, 0);
    pix(6'd0, 1, 1, 1, 0);
    chk("sep_vs", 12'(vs_out), 12'd0);
    chk("sep_hs", 12'(hs_out), 12'd1);

    // Reset mid-line with data in flight
    pix(6'd50, 0, 0, 0, 0);
    pix(6'd50, 0, 0, 0, 0);
    chk("inflight_r", 12'(r_out), 12'd50);
    chk("inflight_hs", 12'(hs_out), 12'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_r", 12'(r_out), 12'd0);
    chk("async_hs", 12'(hs_out), 12'd1);
    chk("async_vs", 12'(vs_out), 12'd1);
    @(negedge clk);
    reset = 1'b0;
    blend = 1'b1; scanlines = 2'b11;
    pix(6'd20, 1, 1, 0, 0);
    pix(6'd40, 1, 1, 0, 0);
    chk("post_rst_unblended", 12'(r_out), 12'd20);
    pix(6'd40, 1, 1, 0, 0);
    chk("post_rst_parity0", 12'(g_out), 12'd30);
    repeat (5) @(negedge clk);
    chk("hold_no_ce", 12'(r_out), 12'd30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
